// File: rtl/wb_arbiter_pipelined.sv
// Round-robin arbiter for NM Wishbone pipelined masters sharing one slave, with a cap on outstanding strobes.
// Optional slave-hang watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_pipelined #(
  parameter int NM      = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MAXOUT  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_cyc,
  input  logic [NM-1:0]    m_stb,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_adr,
  input  logic [NM*DW-1:0] m_dat_w,
  output logic [DW-1:0]    m_dat_r,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_stall,
  output logic [NM-1:0]    m_err,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [AW-1:0]    s_adr,
  output logic [DW-1:0]    s_dat_w,
  input  logic [DW-1:0]    s_dat_r,
  input  logic             s_ack,
  input  logic             s_stall
);

  localparam int IW = $clog2(NM);
  localparam logic [3:0] MAX_C = 4'(MAXOUT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [3:0]    out_cnt_q, out_cnt_d;
  logic          timeout_hit;

  assign m_dat_r = s_dat_r;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  assign timeout_hit = (state_q == GRANT) && (out_cnt_q != 4'd0) && !s_ack &&
                       (wdog_q == 8'(TIMEOUT - 1));

  always_comb begin
    wdog_d = 8'd0;
    if (state_q == GRANT && !timeout_hit) begin
      if (s_ack)                  wdog_d = 8'd0;
      else if (out_cnt_q != 4'd0) wdog_d = wdog_q + 8'd1;
      else                        wdog_d = wdog_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= 8'd0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^(8'(TIMEOUT));
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    out_cnt_d = out_cnt_q;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_w   = '0;
    m_ack     = '0;
    m_stall   = '1;
    m_err     = '0;
    found     = 1'b0;
    idx       = '0;
    case (state_q)
      IDLE: begin
        // Acks arriving here belong to an aborted cycle and are dropped.
        out_cnt_d = 4'd0;
        if (|m_cyc) begin
          for (int k = 1; k <= NM; k++) begin
            idx = IW'((int'(last_q) + k) % NM);
            if (!found && m_cyc[idx]) begin
              gnt_d = idx;
              found = 1'b1;
            end
          end
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_cyc          = m_cyc[gnt_q];
        s_we           = m_we[gnt_q];
        s_adr          = m_adr[gnt_q*AW +: AW];
        s_dat_w        = m_dat_w[gnt_q*DW +: DW];
        s_stb          = m_stb[gnt_q] & (out_cnt_q < MAX_C);
        m_stall[gnt_q] = s_stall | (out_cnt_q == MAX_C);
        m_ack[gnt_q]   = s_ack;
        case ({s_stb & ~s_stall, s_ack && (out_cnt_q != 4'd0)})
          2'b10:   out_cnt_d = out_cnt_q + 4'd1;
          2'b01:   out_cnt_d = out_cnt_q - 4'd1;
          default: out_cnt_d = out_cnt_q;
        endcase
        if (timeout_hit) begin
          m_err[gnt_q] = 1'b1;
          s_cyc        = 1'b0;
          s_stb        = 1'b0;
          state_d      = IDLE;
          last_d       = gnt_q;
          out_cnt_d    = 4'd0;
        end else if (!m_cyc[gnt_q]) begin
          // Dropping cyc with strobes in flight aborts them.
          state_d   = IDLE;
          last_d    = gnt_q;
          out_cnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= IW'(NM - 1);
      out_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_pipelined.sv
// Directed bench for wb_arbiter_pipelined with a fixed-latency slave model.
module tb_wb_arbiter_pipelined;

  localparam int NM = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic             clk;
  logic             rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat_w;
  logic [DW-1:0]    m_dat_r;
  logic [NM-1:0]    m_ack, m_stall, m_err;
  logic             s_cyc, s_stb, s_we;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dat_w, s_dat_r;
  logic             s_ack, s_stall;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ack_pipe;
  int          ack_dly = 1;
  bit          ack_en  = 1'b1;

  wb_arbiter_pipelined #(.NM(NM), .AW(AW), .DW(DW), .MAXOUT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_stall(m_stall), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_stall(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave acks each accepted strobe ack_dly cycles later, whether or not cyc is still up.
  always @(posedge clk) begin
    if (rst) ack_pipe <= '0;
    else     ack_pipe <= {ack_pipe[14:0], s_cyc & s_stb & ~s_stall};
  end
  always_comb s_ack = ack_en & ack_pipe[ack_dly-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
    ack_en = 1'b1; ack_dly = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, acks, maxc, errcyc;
    bit stall_seen, stall_bad, leak, saw_sack, errseen;

    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
    s_stall = 1'b0; s_dat_r = 16'hA5C3;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_scyc",  {31'd0, s_cyc}, 0);
    chk("rst_stall", {30'd0, m_stall}, 2'b11);
    chk("rst_ack",   {30'd0, m_ack}, 0);
    chk("rst_err",   {30'd0, m_err}, 0);
    chk("rst_cnt",   {28'd0, dut.out_cnt_q}, 0);
    rst = 1'b0;

    // 1: three pipelined reads from m0, zero-wait slave
    @(negedge clk); m_cyc = 2'b01; m_stb = 2'b01; m_adr[15:0] = 16'h0010; #1;
    chk("t1_idle_scyc", {31'd0, s_cyc}, 0);
    @(negedge clk); #1;
    chk("t1_scyc",  {31'd0, s_cyc}, 1);
    chk("t1_adr0",  {16'd0, s_adr}, 16'h0010);
    chk("t1_stall", {30'd0, m_stall}, 2'b10);
    @(negedge clk); m_adr[15:0] = 16'h0011; #1;
    chk("t1_ack_a", {30'd0, m_ack}, 2'b01);
    chk("t1_adr1",  {16'd0, s_adr}, 16'h0011);
    chk("t1_dat_r", {16'd0, m_dat_r}, 16'hA5C3);
    @(negedge clk); m_adr[15:0] = 16'h0012; #1;
    chk("t1_ack_b", {30'd0, m_ack}, 2'b01);
    @(negedge clk); m_stb = 2'b00; #1;
    chk("t1_ack_c", {30'd0, m_ack}, 2'b01);
    @(negedge clk); #1;
    chk("t1_ack_end", {30'd0, m_ack}, 0);
    chk("t1_cnt", {28'd0, dut.out_cnt_q}, 0);
    m_cyc = 2'b00;
    @(negedge clk); #1;
    chk("t1_rel", {31'd0, s_cyc}, 0);

    // 2: simultaneous requests, round-robin order
    do_reset();
    @(negedge clk); m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11; m_adr = {16'h0030, 16'h0020}; #1;
    chk("t2_idle", {31'd0, s_cyc}, 0);
    @(negedge clk); #1;
    chk("t2_first_m0", {30'd0, m_stall}, 2'b10);
    chk("t2_adr_m0", {16'd0, s_adr}, 16'h0020);
    chk("t2_we", {31'd0, s_we}, 1);
    @(negedge clk); m_stb = 2'b10; #1;
    chk("t2_ack_m0", {30'd0, m_ack}, 2'b01);
    @(negedge clk); m_cyc = 2'b10; #1;
    chk("t2_rel_scyc", {31'd0, s_cyc}, 0);
    @(negedge clk); #1;
    chk("t2_gap", {30'd0, m_stall}, 2'b11);
    @(negedge clk); #1;
    chk("t2_second_m1", {30'd0, m_stall}, 2'b01);
    chk("t2_adr_m1", {16'd0, s_adr}, 16'h0030);
    @(negedge clk); m_stb = 2'b00; #1;
    chk("t2_ack_m1", {30'd0, m_ack}, 2'b10);
    @(negedge clk); m_cyc = 2'b00;
    @(negedge clk); m_cyc = 2'b11;
    @(negedge clk); #1;
    chk("t2_rr_m0", {30'd0, m_stall}, 2'b10);
    m_cyc = 2'b10;
    @(negedge clk); m_cyc = 2'b11;
    @(negedge clk); #1;
    chk("t2_rr_m1", {30'd0, m_stall}, 2'b01);
    m_cyc = 2'b00;

    // 3: six strobes against a 4-cycle slave, throttled at four in flight
    do_reset();
    ack_dly = 4;
    sent = 0; acks = 0; maxc = 0; stall_seen = 0; stall_bad = 0;
    @(negedge clk); m_cyc = 2'b01;
    for (int c = 0; c < 60 && acks < 6; c++) begin
      @(negedge clk); m_stb[0] = (sent < 6); #1;
      if (m_ack[0]) acks++;
      if (int'(dut.out_cnt_q) > maxc) maxc = int'(dut.out_cnt_q);
      if (dut.out_cnt_q == 4'd4) stall_seen = 1;
      if (m_stall[0] != (dut.out_cnt_q == 4'd4)) stall_bad = 1;
      if (dut.out_cnt_q == 4'd4 && s_stb) stall_bad = 1;
      if (m_stb[0] && !m_stall[0]) sent++;
    end
    chk("t3_acks", acks, 6);
    chk("t3_sent", sent, 6);
    chk("t3_maxcnt", maxc, 4);
    chk("t3_stall_seen", {31'd0, stall_seen}, 1);
    chk("t3_stall_rule", {31'd0, stall_bad}, 0);
    m_stb = 2'b00;
    @(negedge clk); #1;
    chk("t3_cnt_end", {28'd0, dut.out_cnt_q}, 0);
    m_cyc = 2'b00;

    // 4: abort with two outstanding, late acks must not reach any master
    do_reset();
    ack_dly = 3;
    @(negedge clk); m_cyc = 2'b01; m_stb = 2'b01;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); m_stb = 2'b00; m_cyc = 2'b00; #1;
    chk("t4_cnt_before", {28'd0, dut.out_cnt_q}, 2);
    leak = 0; saw_sack = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (c == 0) begin
        chk("t4_idle_scyc", {31'd0, s_cyc}, 0);
        chk("t4_idle_cnt", {28'd0, dut.out_cnt_q}, 0);
      end
      if (s_ack) saw_sack = 1;
      if (m_ack != 2'b00) leak = 1;
    end
    chk("t4_late_ack_seen", {31'd0, saw_sack}, 1);
    chk("t4_no_leak", {31'd0, leak}, 0);
    @(negedge clk); m_cyc = 2'b10;
    @(negedge clk); #1;
    chk("t4_m1_gnt", {30'd0, m_stall}, 2'b01);
    chk("t4_m1_cnt", {28'd0, dut.out_cnt_q}, 0);
    m_cyc = 2'b00;

    // 5: slave never acks a strobe
    do_reset();
    ack_en = 1'b0;
    @(negedge clk); m_cyc = 2'b01; m_stb = 2'b01;
    @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
    errcyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); m_stb = 2'b00; #1;
      if (m_err != 2'b00) begin
        errcyc = k;
        chk("t5_err_vec", {30'd0, m_err}, 2'b01);
        chk("t5_err_scyc", {31'd0, s_cyc}, 0);
        break;
      end
    end
    chk("t5_err_cycle", errcyc, 8);
    @(negedge clk); #1;
    chk("t5_idle_scyc", {31'd0, s_cyc}, 0);
    chk("t5_err_once", {30'd0, m_err}, 0);
    chk("t5_idle_cnt", {28'd0, dut.out_cnt_q}, 0);
`else
    errseen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); m_stb = 2'b00; #1;
      if (m_err != 2'b00) errseen = 1;
    end
    chk("t5_no_err", {31'd0, errseen}, 0);
    chk("t5_hold", {31'd0, s_cyc}, 1);
    chk("t5_hold_cnt", {28'd0, dut.out_cnt_q}, 1);
`endif
    m_cyc = 2'b00;
    ack_en = 1'b1;

    // 6: reset while m1 holds the grant with three outstanding
    do_reset();
    ack_dly = 8;
    @(negedge clk); m_cyc = 2'b01;
    @(negedge clk);
    @(negedge clk); m_cyc = 2'b00;
    @(negedge clk); m_cyc = 2'b10; m_stb = 2'b10;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); m_stb = 2'b00; #1;
    chk("t6_cnt_before", {28'd0, dut.out_cnt_q}, 3);
    rst = 1'b1; m_cyc = 2'b11;
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_scyc", {31'd0, s_cyc}, 0);
    chk("t6_cnt", {28'd0, dut.out_cnt_q}, 0);
    @(negedge clk); #1;
    chk("t6_m0_prio", {30'd0, m_stall}, 2'b10);
    m_cyc = 2'b00;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
